// File: rtl/demux_stream.sv
// demux_stream: routes one input stream to N_OUT show-ahead FIFO channels.
// Ports: clk/rst_n, in_valid/in_ready/in_sel/in_data, out_valid/out_ready/out_data, err_sel, drop_cnt.
module demux_stream #(
  parameter int DATA_W    = 8,
  parameter int N_OUT     = 4,
  parameter int SEL_W     = 2,
  parameter int DEPTH     = 2,
  parameter int HOLD_LAST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [DATA_W-1:0]       in_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    err_sel,
  output logic [7:0]              drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [SEL_W:0] SEL_LIM = (SEL_W+1)'(N_OUT);

  logic [DATA_W-1:0] r_mem  [N_OUT][DEPTH];
  logic [PW-1:0]     r_wptr [N_OUT];
  logic [PW-1:0]     r_rptr [N_OUT];
  logic [PW:0]       r_cnt  [N_OUT];
  logic [DATA_W-1:0] r_hold [N_OUT];
  logic              r_err;
  logic [7:0]        r_drop;

  logic              w_sel_ok;
  logic              w_sel_full;
  logic              w_acc;
  logic [N_OUT-1:0]  w_push;
  logic [N_OUT-1:0]  w_pop;

  always_comb begin
    w_sel_ok   = {1'b0, in_sel} < SEL_LIM;
    w_sel_full = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (in_sel == SEL_W'(i))
        w_sel_full = (r_cnt[i] == CNT_FULL);
    end
    // Out-of-range selects are always accepted so they can be dropped.
    in_ready = w_sel_ok ? !w_sel_full : 1'b1;
    w_acc    = in_valid && in_ready;
    for (int i = 0; i < N_OUT; i++) begin
      w_push[i] = w_acc && w_sel_ok && (in_sel == SEL_W'(i));
      // Pop only decided on pre-edge occupancy: no push-to-pop bypass.
      w_pop[i]  = (r_cnt[i] != '0) && out_ready[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
        r_hold[i] <= '0;
        for (int j = 0; j < DEPTH; j++)
          r_mem[i][j] <= '0;
      end
      r_err  <= 1'b0;
      r_drop <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wptr[i]] <= in_data;
          r_wptr[i]           <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
          if (HOLD_LAST != 0)
            r_hold[i] <= r_mem[i][r_rptr[i]];
        end
        r_cnt[i] <= r_cnt[i]
                  + {{PW{1'b0}}, w_push[i]}
                  - {{PW{1'b0}}, w_pop[i]};
      end
      r_err <= w_acc && !w_sel_ok;
      if (w_acc && !w_sel_ok && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_valid[g] = (r_cnt[g] != '0);
    assign out_data[g*DATA_W +: DATA_W] =
      out_valid[g] ? r_mem[g][r_rptr[g]] : r_hold[g];
  end

  assign err_sel  = r_err;
  assign drop_cnt = r_drop;

endmodule
